afe_seq_ctrl: RTL

// Top-level sequencer for the AFE register path. Drives addr_sel mode/begin inputs to run: reg-0 write,

---
 rtl/pulseox_pkg.sv | 42 ++++
 rtl/afe_seq_ctrl_rdy_sync.sv | 30 +++
 rtl/afe_seq_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pulseox_pkg.sv
// Shared definitions for the AFE register-path sequencer: addr_sel modes,
// sequencer states and the AFE register map landmarks.
package pulseox_pkg;

  localparam logic [2:0] MODE_IDLE = 3'b000;
  localparam logic [2:0] MODE_WR0  = 3'b001;
  localparam logic [2:0] MODE_DIAG = 3'b010;
  localparam logic [2:0] MODE_CFG  = 3'b011;
  localparam logic [2:0] MODE_STRM = 3'b100;

  localparam logic [5:0] REG_WR0        = 6'd0;
  localparam logic [5:0] REG_CFG_LAST   = 6'd35;
  localparam logic [5:0] REG_STRM_FIRST = 6'd42;
  localparam logic [5:0] REG_STRM_LAST  = 6'd47;
  localparam logic [5:0] REG_DIAG       = 6'd48;

  typedef enum logic [4:0] {
    S_IDLE, S_W0_SET, S_W0_GO, S_W0_WAIT, S_GAP_W0,
    S_CFG_SET, S_CFG_GO, S_CFG_WAIT, S_GAP_CFG,
    S_DG_SET, S_DG_GO, S_DG_WAIT, S_GAP_DG,
    S_STRM_IDLE, S_ST_SET, S_ST_GO, S_ST_WAIT, S_FAULT
  } seq_state_e;

  function automatic logic [2:0] mode_of(input seq_state_e s);
    case (s)
      S_W0_SET, S_W0_GO, S_W0_WAIT:    return MODE_WR0;
      S_CFG_SET, S_CFG_GO, S_CFG_WAIT: return MODE_CFG;
      S_DG_SET, S_DG_GO, S_DG_WAIT:    return MODE_DIAG;
      S_ST_SET, S_ST_GO, S_ST_WAIT:    return MODE_STRM;
      default:                         return MODE_IDLE;
    endcase
  endfunction

  function automatic logic is_wait(input seq_state_e s);
    return (s == S_W0_WAIT) || (s == S_CFG_WAIT) || (s == S_DG_WAIT) || (s == S_ST_WAIT);
  endfunction

  function automatic logic is_frame(input seq_state_e s);
    return (s == S_ST_SET) || (s == S_ST_GO) || (s == S_ST_WAIT);
  endfunction

endpackage

// File: rtl/afe_seq_ctrl_rdy_sync.sv
// ADC_RDY synchronizer: two metastability flops, a history flop and a
// registered rising-edge pulse (edge visible on the third clock after the pin rises).
module rdy_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [2:0] sh_q, sh_d;
  logic       rise_q, rise_d;

  always_comb begin
    sh_d   = {sh_q[1:0], async_in};
    rise_d = sh_q[1] & ~sh_q[2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      rise_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      rise_q <= rise_d;
    end
  end

  always_comb rise = rise_q;

endmodule

// File: rtl/afe_seq_ctrl.sv
// AFE register-path sequencer: reg-0 write, config sweep, optional diag read,
// then one 42..47 stream sweep per ADC_RDY edge, with timeout and overrun flags.
module afe_seq_ctrl
  import pulseox_pkg::*;
#(
  parameter int unsigned       P_TO_W    = 20,
  parameter logic [P_TO_W-1:0] P_TIMEOUT = 20'd500000,
  parameter bit                P_DIAG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        in_reset,
  input  logic        in_start,
  input  logic        in_stop,
  input  logic        in_adc_rdy,
  input  logic        in_rw_done,
  input  logic        in_cyc_done,
  input  logic        in_strm_dn,
  output logic [2:0]  out_addr_sel_rw,
  output logic        out_r_begin,
  output logic        out_w_begin,
  output logic        out_cfg_done,
  output logic        out_diag_done,
  output logic        out_frame_valid,
  output logic [15:0] out_frame_cnt,
  output logic        out_ovr,
  output logic        out_err
);

  localparam logic [P_TO_W-1:0] TO_LAST = P_TIMEOUT - 1'b1;

  seq_state_e        state_q, state_d;
  logic [P_TO_W-1:0] to_q, to_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              pend_q, pend_d, stop_q, stop_d, ovr_q, ovr_d, err_q, err_d;
  logic              cfg_done_q, cfg_done_d, diag_done_q, diag_done_d, fv_q, fv_d;
  logic              rdy_rise, to_hit, restart, fault;

  rdy_sync u_rdy_sync (
    .clk      (clk),
    .rst      (in_reset),
    .async_in (in_adc_rdy),
    .rise     (rdy_rise)
  );

  always_comb to_hit = is_wait(state_q) && (to_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    to_d        = is_wait(state_q) ? to_q + 1'b1 : '0;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    stop_d      = stop_q;
    ovr_d       = ovr_q;
    err_d       = err_q;
    cfg_done_d  = cfg_done_q;
    diag_done_d = 1'b0;
    fv_d        = 1'b0;
    restart     = 1'b0;
    fault       = 1'b0;

    if (is_frame(state_q)) begin
      if (rdy_rise) begin
        if (pend_q) ovr_d = 1'b1;
        else        pend_d = 1'b1;
      end
      if (in_stop) stop_d = 1'b1;
    end

    case (state_q)
      S_IDLE:     if (in_start) restart = 1'b1;
      S_W0_SET:   state_d = S_W0_GO;
      S_W0_GO:    state_d = S_W0_WAIT;
      S_W0_WAIT:  if (in_rw_done) state_d = S_GAP_W0; else if (to_hit) fault = 1'b1;
      S_GAP_W0:   state_d = S_CFG_SET;
      S_CFG_SET:  state_d = S_CFG_GO;
      S_CFG_GO:   state_d = S_CFG_WAIT;
      S_CFG_WAIT: if (in_cyc_done) state_d = S_GAP_CFG; else if (to_hit) fault = 1'b1;
      S_GAP_CFG:  state_d = P_DIAG_EN ? S_DG_SET : S_STRM_IDLE;
      S_DG_SET:   state_d = S_DG_GO;
      S_DG_GO:    state_d = S_DG_WAIT;
      S_DG_WAIT: begin
        if (in_rw_done) begin
          state_d     = S_GAP_DG;
          diag_done_d = 1'b1;
        end else if (to_hit) begin
          fault = 1'b1;
        end
      end
      S_GAP_DG:   state_d = S_STRM_IDLE;
      S_STRM_IDLE: begin
        if (in_start) begin
          restart = 1'b1;
        end else if (in_stop) begin
          state_d = S_IDLE;
          pend_d  = 1'b0;
        end else if (rdy_rise || pend_q) begin
          // A fresh edge arriving while a pending one is consumed becomes the new pending.
          state_d = S_ST_SET;
          pend_d  = pend_q & rdy_rise;
        end
      end
      S_ST_SET:   state_d = S_ST_GO;
      S_ST_GO:    state_d = S_ST_WAIT;
      S_ST_WAIT: begin
        if (in_strm_dn) begin
          fv_d   = 1'b1;
          cnt_d  = cnt_q + 16'd1;
          stop_d = 1'b0;
          if (stop_q || in_stop) begin
            state_d = S_IDLE;
            pend_d  = 1'b0;
          end else begin
            state_d = S_STRM_IDLE;
          end
        end else if (to_hit) begin
          fault = 1'b1;
        end
      end
      S_FAULT:    if (in_start) restart = 1'b1;
      default:    state_d = S_IDLE;
    endcase

    if (state_d == S_STRM_IDLE) cfg_done_d = 1'b1;

    if (fault) begin
      state_d    = S_FAULT;
      err_d      = 1'b1;
      cfg_done_d = 1'b0;
      pend_d     = 1'b0;
      stop_d     = 1'b0;
    end

    if (restart) begin
      state_d    = S_W0_SET;
      cnt_d      = '0;
      ovr_d      = 1'b0;
      err_d      = 1'b0;
      cfg_done_d = 1'b0;
      pend_d     = 1'b0;
      stop_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_reset) begin
      state_q     <= S_IDLE;
      to_q        <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      stop_q      <= 1'b0;
      ovr_q       <= 1'b0;
      err_q       <= 1'b0;
      cfg_done_q  <= 1'b0;
      diag_done_q <= 1'b0;
      fv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_q        <= to_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      stop_q      <= stop_d;
      ovr_q       <= ovr_d;
      err_q       <= err_d;
      cfg_done_q  <= cfg_done_d;
      diag_done_q <= diag_done_d;
      fv_q        <= fv_d;
    end
  end

  always_comb begin
    out_addr_sel_rw = mode_of(state_q);
    out_w_begin     = (state_q == S_W0_GO) || (state_q == S_CFG_GO);
    out_r_begin     = (state_q == S_DG_GO) || (state_q == S_ST_GO);
    out_cfg_done    = cfg_done_q;
    out_diag_done   = diag_done_q;
    out_frame_valid = fv_q;
    out_frame_cnt   = cnt_q;
    out_ovr         = ovr_q;
    out_err         = err_q;
  end

endmodule
